// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length modes, S-box and GF(2^8) helpers.
// Also holds the expander's two-state FSM encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        AES_128     = 2'b00,
        AES_192     = 2'b01,
        AES_256     = 2'b10,
        AES_ILLEGAL = 2'b11
    } aes_mode_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } exp_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [3:0] nk_of(input aes_mode_e mode);
        case (mode)
            AES_128: return 4'd4;
            AES_192: return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_e mode);
        return nk_of(mode) + 4'd6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: byte-wise S-box substitution of one 32-bit schedule word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key expansion, one schedule word per cycle, into an internal
// round-key buffer with a random-access 128-bit read port.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int MAX_NK  = 8,
    parameter bit REG_OUT = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [1:0]   mode_i,
    input  logic [255:0] key_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         valid_o,
    output logic         err_o,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         rk_err_o
);

    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    exp_state_e   r_state;
    exp_state_e   w_state_next;
    logic [3:0]   r_nk;
    logic [3:0]   r_nr;
    logic [AW-1:0] r_i;
    logic [2:0]   r_j;
    logic [7:0]   r_rcon;
    logic         r_valid;
    logic         r_done;
    logic         r_err;
    logic [31:0]  r_buf [DEPTH];

    logic         w_legal;
    logic         w_accept;
    logic         w_reject;
    logic         w_expand;
    logic         w_last;
    logic [3:0]   w_nk_in;
    logic [5:0]   w_nw;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub_out;
    logic [31:0]  w_t;
    logic [31:0]  w_new;

    assign w_nk_in  = nk_of(aes_mode_e'(mode_i));
    assign w_legal  = (mode_i != AES_ILLEGAL) && (int'(w_nk_in) <= MAX_NK);
    assign w_accept = (r_state == S_IDLE) && start_i && w_legal;
    assign w_reject = (r_state == S_IDLE) && start_i && !w_legal;
    assign w_expand = (r_state == S_EXPAND);
    assign w_nw     = {r_nr + 4'd1, 2'b00};
    assign w_last   = w_expand && (6'(r_i) == w_nw - 6'd1);

    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (w_accept) w_state_next = S_EXPAND;
            end
            S_EXPAND: begin
                busy_o = 1'b1;
                if (w_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One S-box bank serves both the rotated (j==0) and plain (Nk==8, j==4) paths.
    assign w_prev   = r_buf[r_i - AW'(1)];
    assign w_back   = r_buf[r_i - AW'(r_nk)];
    assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_t = w_prev;
        if (r_j == 3'd0)
            w_t = w_sub_out ^ {r_rcon, 24'h000000};
        else if ((r_nk == 4'd8) && (r_j == 3'd4))
            w_t = w_sub_out;
    end

    assign w_new = w_back ^ w_t;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_nk    <= 4'd4;
            r_nr    <= 4'd10;
            r_i     <= '0;
            r_j     <= '0;
            r_rcon  <= RCON_INIT;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            r_err   <= w_reject;
            if (w_accept) begin
                r_nk    <= w_nk_in;
                r_nr    <= nr_of(aes_mode_e'(mode_i));
                r_valid <= 1'b0;
                r_rcon  <= RCON_INIT;
                r_i     <= AW'(w_nk_in);
                r_j     <= '0;
            end else if (w_expand) begin
                r_i <= r_i + AW'(1);
                r_j <= ({1'b0, r_j} == r_nk - 4'd1) ? 3'd0 : r_j + 3'd1;
                if (r_j == 3'd0) r_rcon <= xtime(r_rcon);
                if (w_last) begin
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    // NOTE: the round-key buffer has no reset; valid_o alone says whether its contents mean anything.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_accept) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(w_nk_in)) r_buf[k] <= key_i[255 - 32*k -: 32];
                end
            end else if (w_expand) begin
                r_buf[r_i] <= w_new;
            end
        end
    end

    assign done_o  = r_done;
    assign valid_o = r_valid;
    assign err_o   = r_err;

    logic [AW-1:0] w_base;
    logic          w_rd_err;
    logic [127:0]  w_rk;

    assign w_base   = AW'({rk_idx_i, 2'b00});
    assign w_rd_err = (rk_idx_i > r_nr);
    assign w_rk     = w_rd_err ? '0 : {r_buf[w_base], r_buf[w_base + AW'(1)],
                                       r_buf[w_base + AW'(2)], r_buf[w_base + AW'(3)]};

    if (REG_OUT) begin : g_reg_out
        logic [127:0] r_rk;
        logic         r_rk_err;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rk     <= '0;
                r_rk_err <= 1'b0;
            end else begin
                r_rk     <= w_rk;
                r_rk_err <= w_rd_err;
            end
        end
        assign rk_o     = r_rk;
        assign rk_err_o = r_rk_err;
    end else begin : g_comb_out
        assign rk_o     = w_rk;
        assign rk_err_o = w_rd_err;
    end

endmodule
